// File: rtl/nf_trace_uart_tx.sv
// nf_trace_uart_tx -- nanoFOX hardware trace transmitter.
// Captures (pc, instr) on each rising edge of the CPU step strobe and queues the
// records in a small FIFO. Each record is sent over a UART 8N1 line as one frame:
// 0xA5 sync, pc bytes (LSB first), then instr bytes (LSB first).
// Optional feature macro: NF_TRACE_CHECKSUM_EN. When it is defined, a 10th byte is
// appended that holds the XOR of the 8 payload bytes. When it is undefined, frames
// are 9 bytes long and no checksum logic is built.
// Reset is synchronous and active-low (resetn).

module nf_trace_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 434
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        trace_en_i,
    input  logic        cpu_en_i,
    input  logic [31:0] instr_addr_i,
    input  logic [31:0] instr_i,
    input  logic        ovf_clr_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic [7:0]  drop_cnt_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

`ifdef NF_TRACE_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd9;

    // XOR of the eight payload bytes of a record (sync byte excluded)
    function automatic logic [7:0] payload_xor(input logic [63:0] rec);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ rec[8*i +: 8];
        end
        return acc;
    endfunction
`else
    localparam logic [3:0] LAST_BYTE = 4'd8;
`endif

    logic             cpu_en_q;
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic [63:0]      rec_q, rec_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             cap_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [7:0]       cur_byte_s;

    // Capture qualifier and FIFO status; a pop in the same cycle frees a slot for the push
    assign cap_s    = cpu_en_i & ~cpu_en_q & trace_en_i;
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push_s   = cap_s & (~full_s | pop_s);
    assign drop_s   = cap_s & full_s & ~pop_s;
    assign wr_ptr_d = wr_ptr_q + (PW+1)'(push_s);
    assign rd_ptr_d = rd_ptr_q + (PW+1)'(pop_s);
    assign busy_d   = (state_d != ST_IDLE) | (wr_ptr_d != rd_ptr_d);

    // Select the frame byte currently being serialized
    always_comb begin
        cur_byte_s = 8'hFF;
        case (byte_idx_q)
            4'd0:    cur_byte_s = 8'hA5;
            4'd1:    cur_byte_s = rec_q[7:0];
            4'd2:    cur_byte_s = rec_q[15:8];
            4'd3:    cur_byte_s = rec_q[23:16];
            4'd4:    cur_byte_s = rec_q[31:24];
            4'd5:    cur_byte_s = rec_q[39:32];
            4'd6:    cur_byte_s = rec_q[47:40];
            4'd7:    cur_byte_s = rec_q[55:48];
            4'd8:    cur_byte_s = rec_q[63:56];
`ifdef NF_TRACE_CHECKSUM_EN
            4'd9:    cur_byte_s = payload_xor(rec_q);
`endif
            default: cur_byte_s = 8'hFF;
        endcase
    end

    // Frame sequencer: every state lasts CLK_DIV cycles; a new record reloads straight after the last stop bit
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        rec_d      = rec_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    rec_d      = mem_q[rd_ptr_q[PW-1:0]];
                    byte_idx_d = 4'd0;
                    cnt_d      = '0;
                    state_d    = ST_START;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_START, ST_DATA, ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (state_q == ST_START) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else if (state_q == ST_DATA) begin
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        if (byte_idx_q == LAST_BYTE) begin
                            if (!empty_s) begin
                                pop_s      = 1'b1;
                                rec_d      = mem_q[rd_ptr_q[PW-1:0]];
                                byte_idx_d = 4'd0;
                                state_d    = ST_START;
                            end else begin
                                state_d    = ST_IDLE;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 4'd1;
                            state_d    = ST_START;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the current state; registered so tx never glitches
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = cur_byte_s[bit_idx_q];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // Overflow bookkeeping; a clear wins over a simultaneous drop
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'h00;
        end else if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control and status registers; reset abandons any frame and flushes the FIFO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_en_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 4'd0;
            rec_q      <= 64'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            cpu_en_q   <= cpu_en_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            rec_q      <= rec_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {instr_i, instr_addr_i};
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
